aes_masked_mixcol_serial: RTL and testbench

// - Byte-serial, 2-share (d=1) masked MixColumns stage. Sits directly downstream of the masked SubBytes output stage.
// - Collects 4 masked S-box output bytes (one column, share 0 and share 1), applies MixColumns to each share independently,

---
 rtl/aes_masked_pkg.sv | 19 +
 rtl/aes_mc_column_share.sv | 17 +
 rtl/aes_masked_mixcol_serial.sv | 123 ++++++++++++
 tb/tb_aes_masked_mixcol_serial.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_masked_pkg.sv
// Shared types and GF(2^8) helpers for the masked AES datapath stages.
// Everything here is share-agnostic: constants are never mixed into a share.
package aes_masked_pkg;

    localparam logic [7:0] AES_POLY = 8'h1b;

    typedef enum logic {
        COLLECT = 1'b0,
        EMIT    = 1'b1
    } mc_state_t;

    // [k] is row k of the column; byte 0 = row 0
    typedef logic [3:0][7:0] col_t;

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? AES_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/aes_mc_column_share.sv
// Combinational MixColumns on one share of one column; purely linear, no constant terms.
// Zero latency, no flow control.
module aes_mc_column_share
    import aes_masked_pkg::*;
(
    input  col_t col_i,
    output col_t col_o
);

    for (genvar k = 0; k < 4; k++) begin : g_row
        localparam int K1 = (k + 1) % 4;
        localparam int K2 = (k + 2) % 4;
        localparam int K3 = (k + 3) % 4;
        assign col_o[k] = xtime(col_i[k]) ^ xtime(col_i[K1]) ^ col_i[K1] ^ col_i[K2] ^ col_i[K3];
    end

endmodule

// File: rtl/aes_masked_mixcol_serial.sv
// Byte-serial 2-share MixColumns: collect 4 bytes, emit 4 MixColumns (or bypassed) bytes per share.
// Byte 3 in -> byte 0 out is 1 cycle; input stalls during emit, outputs hold while out_ready is low.
module aes_masked_mixcol_serial
    import aes_masked_pkg::*;
#(
    parameter int OUT_REG    = 1,
    parameter int CLR_ON_POP = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in0,
    input  logic [7:0] in1,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       last_round,
    output logic [7:0] out0,
    output logic [7:0] out1,
    output logic       out_valid,
    input  logic       out_ready
);

    mc_state_t  state_q, state_d;
    logic [1:0] idx_q, idx_d;
    col_t       a0_q, a0_d, a1_q, a1_d;
    logic       lr_q, lr_d;
    logic [7:0] out0_q, out0_d, out1_q, out1_d;

    logic       load_out, clr_out;
    col_t       src0, src1, mc0, mc1;
    logic       sel_lr;
    logic [1:0] sel_idx;
    logic [7:0] byte0, byte1;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        a0_d     = a0_q;
        a1_d     = a1_q;
        lr_d     = lr_q;
        load_out = 1'b0;
        clr_out  = 1'b0;
        case (state_q)
            COLLECT: begin
                if (in_valid) begin
                    a0_d[idx_q] = in0;
                    a1_d[idx_q] = in1;
                    idx_d       = idx_q + 2'd1;
                    if (idx_q == 2'd0) lr_d = last_round;
                    if (idx_q == 2'd3) begin
                        state_d  = EMIT;
                        load_out = 1'b1;
                    end
                end
            end
            EMIT: begin
                if (out_ready) begin
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        state_d = COLLECT;
                        clr_out = 1'b1;
                        if (CLR_ON_POP != 0) begin
                            a0_d = '0;
                            a1_d = '0;
                        end
                    end else begin
                        load_out = 1'b1;
                    end
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    // The output register looks one byte ahead, so it reads the next-state buffer and index.
    assign src0    = (OUT_REG != 0) ? a0_d  : a0_q;
    assign src1    = (OUT_REG != 0) ? a1_d  : a1_q;
    assign sel_lr  = (OUT_REG != 0) ? lr_d  : lr_q;
    assign sel_idx = (OUT_REG != 0) ? idx_d : idx_q;

    aes_mc_column_share u_mc_share0 (.col_i(src0), .col_o(mc0));
    aes_mc_column_share u_mc_share1 (.col_i(src1), .col_o(mc1));

    assign byte0 = sel_lr ? src0[sel_idx] : mc0[sel_idx];
    assign byte1 = sel_lr ? src1[sel_idx] : mc1[sel_idx];

    always_comb begin
        out0_d = out0_q;
        out1_d = out1_q;
        if (load_out) begin
            out0_d = byte0;
            out1_d = byte1;
        end else if (clr_out) begin
            out0_d = 8'h00;
            out1_d = 8'h00;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= COLLECT;
            idx_q   <= 2'd0;
            a0_q    <= '0;
            a1_q    <= '0;
            lr_q    <= 1'b0;
            out0_q  <= 8'h00;
            out1_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a0_q    <= a0_d;
            a1_q    <= a1_d;
            lr_q    <= lr_d;
            out0_q  <= out0_d;
            out1_q  <= out1_d;
        end
    end

    assign in_ready  = (state_q == COLLECT) && !rst;
    assign out_valid = (state_q == EMIT);
    assign out0      = (OUT_REG != 0) ? out0_q : (out_valid ? byte0 : 8'h00);
    assign out1      = (OUT_REG != 0) ? out1_q : (out_valid ? byte1 : 8'h00);

endmodule

// File: tb/tb_aes_masked_mixcol_serial.sv
// Randomised and directed bench for the serial masked MixColumns stage.
// Expected share bytes come from a GF(2^8) multiply model of MixColumns kept in the bench.
module tb_aes_masked_mixcol_serial;

    typedef logic [3:0][7:0] tcol_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] in0 = 8'h00;
    logic [7:0] in1 = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       last_round = 1'b0;
    logic [7:0] out0, out1;
    logic       out_valid;
    logic       out_ready = 1'b1;

    always #5 clk = ~clk;

    aes_masked_mixcol_serial dut (
        .clk       (clk),
        .rst       (rst),
        .in0       (in0),
        .in1       (in1),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .last_round(last_round),
        .out0      (out0),
        .out1      (out1),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    int n_pass = 0;
    int n_chk  = 0;
    logic [7:0] exp0_q[$];
    logic [7:0] exp1_q[$];
    logic [7:0] log0[$];
    logic [7:0] log1[$];
    int pops    = 0;
    int rd_mode = 0;
    int rd_cnt  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] acc;
        logic [15:0] p;
        p = 16'h0;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
        for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011b << (i - 8));
        acc = p[8:0];
        return acc[7:0];
    endfunction

    function automatic tcol_t mix(input tcol_t c);
        tcol_t r;
        for (int k = 0; k < 4; k++)
            r[k] = gmul(8'h02, c[k]) ^ gmul(8'h03, c[(k + 1) % 4]) ^ c[(k + 2) % 4] ^ c[(k + 3) % 4];
        return r;
    endfunction

    function automatic tcol_t mkcol(input logic [7:0] b0, b1, b2, b3);
        return {b3, b2, b1, b0};
    endfunction

    function automatic tcol_t rndcol();
        return tcol_t'($urandom);
    endfunction

    always @(posedge clk) begin
        #1;
        rd_cnt++;
        case (rd_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ((rd_cnt % 3) == 0);
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Compare process: every cycle, away from the rising edge.
    logic       stall = 1'b0;
    logic [7:0] p0 = 8'h00, p1 = 8'h00;
    always @(negedge clk) begin
        if (rst) begin
            chk("rst_out_valid", 32'(out_valid), 32'd0);
            chk("rst_out0", 32'(out0), 32'd0);
            chk("rst_out1", 32'(out1), 32'd0);
            chk("rst_in_ready", 32'(in_ready), 32'd0);
            stall = 1'b0;
        end else begin
            chk("in_ready_vs_out_valid", 32'(in_ready), 32'(!out_valid));
            if (stall) begin
                chk("stall_valid", 32'(out_valid), 32'd1);
                chk("stall_out0", 32'(out0), 32'(p0));
                chk("stall_out1", 32'(out1), 32'(p1));
            end
            if (!out_valid) begin
                chk("idle_out0", 32'(out0), 32'd0);
                chk("idle_out1", 32'(out1), 32'd0);
            end else if (exp0_q.size() == 0) begin
                chk("unexpected_out_valid", 32'(out_valid), 32'd0);
            end else begin
                chk("out0", 32'(out0), 32'(exp0_q[0]));
                chk("out1", 32'(out1), 32'(exp1_q[0]));
                if (out_ready) begin
                    void'(exp0_q.pop_front());
                    void'(exp1_q.pop_front());
                    log0.push_back(out0);
                    log1.push_back(out1);
                    pops++;
                end
            end
            stall = out_valid && !out_ready;
            p0 = out0;
            p1 = out1;
        end
    end

    task automatic send_col(input tcol_t x, input tcol_t m, input logic lr, input int nb,
                            input bit push, input bit gaps);
        tcol_t s0, e0, e1;
        logic acc;
        int tries;
        s0 = x ^ m;
        if (push) begin
            e0 = lr ? s0 : mix(s0);
            e1 = lr ? m : mix(m);
            for (int k = 0; k < 4; k++) begin
                exp0_q.push_back(e0[k]);
                exp1_q.push_back(e1[k]);
            end
        end
        for (int b = 0; b < nb; b++) begin
            if (gaps && ($urandom_range(0, 3) == 0)) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end
            in0 = s0[b];
            in1 = m[b];
            last_round = (b == 0) ? lr : 1'($urandom);
            in_valid = 1'b1;
            tries = 0;
            do begin
                @(negedge clk);
                acc = in_ready;
                @(posedge clk); #1;
                tries++;
            end while (!acc && tries < 500);
            if (!acc) chk("in_accept_timeout", 32'(acc), 32'd1);
        end
        in_valid = 1'b0;
        in0 = 8'($urandom);
        in1 = 8'($urandom);
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while ((exp0_q.size() != 0 || out_valid) && t < 400) begin
            @(negedge clk); #1;
            t++;
        end
        chk("drain_timeout", 32'(exp0_q.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        exp0_q.delete();
        exp1_q.delete();
        #1;
        chk("reset_now_valid", 32'(out_valid), 32'd0);
        chk("reset_now_out0", 32'(out0), 32'd0);
        chk("reset_now_out1", 32'(out1), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic check_xor(input string nm, input tcol_t e);
        chk({nm, "_count"}, 32'(log0.size()), 32'd4);
        for (int k = 0; k < 4 && k < log0.size(); k++)
            chk(nm, 32'(log0[k] ^ log1[k]), 32'(e[k]));
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tcol_t x, m;
        int pst, t;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_in_ready", 32'(in_ready), 32'd0);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post_reset_in_ready", 32'(in_ready), 32'd1);

        chk("model_ref1", 32'(mix(mkcol(8'hdb, 8'h13, 8'h53, 8'h45))), 32'(mkcol(8'h8e, 8'h4d, 8'ha1, 8'hbc)));
        chk("model_ref2", 32'(mix(mkcol(8'hf2, 8'h0a, 8'h22, 8'h5c))), 32'(mkcol(8'h9f, 8'hdc, 8'h58, 8'h9d)));
        chk("model_ref3", 32'(mix(mkcol(8'h01, 8'h01, 8'h01, 8'h01))), 32'(mkcol(8'h01, 8'h01, 8'h01, 8'h01)));

        x = mkcol(8'hdb, 8'h13, 8'h53, 8'h45);
        m = mkcol(8'ha5, 8'h3c, 8'h0f, 8'hf0);
        log0.delete(); log1.delete();
        send_col(x, m, 1'b0, 4, 1'b1, 1'b0);
        wait_drain();
        check_xor("mc_xor", mkcol(8'h8e, 8'h4d, 8'ha1, 8'hbc));

        log0.delete(); log1.delete();
        send_col(x, m, 1'b1, 4, 1'b1, 1'b0);
        wait_drain();
        check_xor("bypass_xor", x);
        for (int k = 0; k < 4 && k < log0.size(); k++) begin
            chk("bypass_share0", 32'(log0[k]), 32'(x[k] ^ m[k]));
            chk("bypass_share1", 32'(log1[k]), 32'(m[k]));
        end

        rd_mode = 1;
        pst = pops;
        log0.delete(); log1.delete();
        send_col(mkcol(8'hf2, 8'h0a, 8'h22, 8'h5c), rndcol(), 1'b0, 4, 1'b1, 1'b0);
        wait_drain();
        check_xor("stall_xor", mkcol(8'h9f, 8'hdc, 8'h58, 8'h9d));
        chk("stall_pop_count", 32'(pops - pst), 32'd4);
        rd_mode = 0;

        // Garbage held on the input during emit must not be taken.
        pst = pops;
        send_col(rndcol(), rndcol(), 1'b0, 4, 1'b1, 1'b0);
        in_valid = 1'b1;
        t = 0;
        forever begin
            in0 = 8'h11 * 8'(t % 4 + 1);
            in1 = 8'h11 * 8'(t % 4 + 1);
            @(negedge clk); #1;
            if (in_ready || t > 50) break;
            t++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk("garbage_pops_before_ready", 32'(pops - pst), 32'd4);
        @(posedge clk); #1;
        send_col(rndcol(), rndcol(), 1'b0, 4, 1'b1, 1'b0);
        wait_drain();

        send_col(rndcol(), rndcol(), 1'b0, 2, 1'b0, 1'b0);
        do_reset();
        log0.delete(); log1.delete();
        send_col(x, m, 1'b0, 4, 1'b1, 1'b0);
        wait_drain();
        check_xor("after_rst_collect_xor", mkcol(8'h8e, 8'h4d, 8'ha1, 8'hbc));

        pst = pops;
        send_col(rndcol(), rndcol(), 1'b0, 4, 1'b1, 1'b0);
        t = 0;
        while (pops < pst + 1 && t < 100) begin
            @(negedge clk); #1;
            t++;
        end
        @(posedge clk); #1;
        chk("mid_emit_valid", 32'(out_valid), 32'd1);
        do_reset();
        log0.delete(); log1.delete();
        send_col(mkcol(8'hf2, 8'h0a, 8'h22, 8'h5c), rndcol(), 1'b0, 4, 1'b1, 1'b0);
        wait_drain();
        check_xor("after_rst_emit_xor", mkcol(8'h9f, 8'hdc, 8'h58, 8'h9d));

        log0.delete(); log1.delete();
        send_col(mkcol(8'h01, 8'h01, 8'h01, 8'h01), '0, 1'b0, 4, 1'b1, 1'b0);
        wait_drain();
        for (int k = 0; k < 4 && k < log0.size(); k++) begin
            chk("zero_share_out1", 32'(log1[k]), 32'd0);
            chk("zero_share_out0", 32'(log0[k]), 32'h01);
        end

        rd_mode = 2;
        for (int c = 0; c < 40; c++) begin
            send_col(rndcol(), rndcol(), 1'($urandom_range(0, 3) == 0), 4, 1'b1, 1'b1);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
        wait_drain();
        rd_mode = 0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
